// File: rtl/pair_scan_controller_if.sv
// Bundles the price-RAM read port and the order handshake of the pair scanner.
// Order handshake: the master raises order_valid with order_pair/pos/spread stable; the transfer
// happens in the cycle where order_valid && order_ready, and only then may the fields change.
interface pair_scan_controller_if #(
  parameter int PRICE_W = 16,
  parameter int ADDR_W  = 8,
  parameter int PAIR_W  = 2
);
  logic               ram_rd_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [PRICE_W-1:0] ram_rd_data;
  logic               order_valid;
  logic               order_ready;
  logic [PAIR_W-1:0]  order_pair;
  logic [1:0]         order_pos;
  logic [PRICE_W:0]   order_spread;

  modport master (
    output ram_rd_en, ram_addr,
    input  ram_rd_data,
    output order_valid, order_pair, order_pos, order_spread,
    input  order_ready
  );

  modport slave (
    input  ram_rd_en, ram_addr,
    output ram_rd_data,
    input  order_valid, order_pair, order_pos, order_spread,
    output order_ready
  );
endinterface

// File: rtl/pair_scan_controller.sv
// Round-robin pair scanner: reads two prices per pair, evaluates the spread against
// entry/exit thresholds with hysteresis, and issues position-change orders.
module pair_scan_controller #(
  parameter int NUM_PAIRS = 4,
  parameter int PRICE_W   = 16,
  parameter int ADDR_W    = 8,
  parameter int RAM_BASE  = 0,
  parameter int THRESHOLD = 100,
  parameter int EXIT_BAND = 20,
  localparam int PAIR_W   = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_en,
  pair_scan_controller_if.master bus,
  output logic                  scan_done,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD1   = 3'd1,
    S_RD2   = 3'd2,
    S_CAP   = 3'd3,
    S_EVAL  = 3'd4,
    S_ISSUE = 3'd5
  } state_t;

  localparam logic [1:0] POS_FLAT  = 2'b00;
  localparam logic [1:0] POS_LONG  = 2'b01;
  localparam logic [1:0] POS_SHORT = 2'b10;

  localparam logic signed [PRICE_W:0] THR_P = (PRICE_W+1)'(THRESHOLD);
  localparam logic signed [PRICE_W:0] THR_N = -THR_P;
  localparam logic signed [PRICE_W:0] EB_P  = (PRICE_W+1)'(EXIT_BAND);
  localparam logic signed [PRICE_W:0] EB_N  = -EB_P;
  localparam logic [PAIR_W-1:0]       LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

  state_t state_q, state_d;

  logic [PAIR_W-1:0]  pair_idx;
  logic [1:0]         pos_q [NUM_PAIRS];
  logic [PRICE_W-1:0] p1_q, p2_q;
  logic [PAIR_W-1:0]  order_pair_q;
  logic [1:0]         order_pos_q;
  logic [PRICE_W:0]   order_spread_q;
  logic               scan_done_q;

  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  base_addr;
  logic               complete;
  logic               load_order;
  logic               last_pair;
  logic signed [PRICE_W:0] spread;
  logic [1:0]         pos_cur;
  logic [1:0]         target;

  assign base_addr = ADDR_W'(RAM_BASE) + ADDR_W'({pair_idx, 1'b0});
  assign last_pair = (pair_idx == LAST_PAIR);
  assign pos_cur   = pos_q[pair_idx];

  // Both prices are zero-extended, so the PRICE_W+1 bit difference never overflows.
  assign spread = $signed({1'b0, p1_q}) - $signed({1'b0, p2_q});

  // Between the entry threshold and the exit band the held position is kept.
  always_comb begin
    target = pos_cur;
    if (spread > THR_P)
      target = POS_LONG;
    else if (spread < THR_N)
      target = POS_SHORT;
    else if ((spread <= EB_P) && (spread >= EB_N))
      target = POS_FLAT;
  end

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    rd_addr    = '0;
    complete   = 1'b0;
    load_order = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_en)
          state_d = S_RD1;
      end
      S_RD1: begin
        rd_en   = 1'b1;
        rd_addr = base_addr;
        state_d = S_RD2;
      end
      S_RD2: begin
        rd_en   = 1'b1;
        rd_addr = base_addr + ADDR_W'(1);
        state_d = S_CAP;
      end
      S_CAP: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (target != pos_cur) begin
          load_order = 1'b1;
          state_d    = S_ISSUE;
        end else begin
          complete = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.order_ready)
          complete = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // scan_en only matters once the current pair is fully done.
    if (complete)
      state_d = scan_en ? S_RD1 : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pair_idx       <= '0;
      p1_q           <= '0;
      p2_q           <= '0;
      order_pair_q   <= '0;
      order_pos_q    <= POS_FLAT;
      order_spread_q <= '0;
      scan_done_q    <= 1'b0;
      for (int k = 0; k < NUM_PAIRS; k++)
        pos_q[k] <= POS_FLAT;
    end else begin
      state_q     <= state_d;
      scan_done_q <= complete && last_pair;
      if (state_q == S_RD2)
        p1_q <= bus.ram_rd_data;
      if (state_q == S_CAP)
        p2_q <= bus.ram_rd_data;
      if (load_order) begin
        order_pair_q   <= pair_idx;
        order_pos_q    <= target;
        order_spread_q <= spread;
      end
      if (complete) begin
        if (state_q == S_ISSUE)
          pos_q[pair_idx] <= order_pos_q;
        pair_idx <= last_pair ? '0 : pair_idx + PAIR_W'(1);
      end
    end
  end

  assign bus.ram_rd_en    = rd_en;
  assign bus.ram_addr     = rd_addr;
  assign bus.order_valid  = (state_q == S_ISSUE);
  assign bus.order_pair   = order_pair_q;
  assign bus.order_pos    = order_pos_q;
  assign bus.order_spread = order_spread_q;

  assign scan_done = scan_done_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pair_scan_controller.sv
// Directed bench for pair_scan_controller: RAM model with 1-cycle read latency,
// hand-computed order/address expectations across entry, hold, exit, stall, pause and reset.
module tb_pair_scan_controller;

  localparam int NUM_PAIRS = 4;
  localparam int PRICE_W   = 16;
  localparam int ADDR_W    = 8;
  localparam int PAIR_W    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_en = 1'b0;
  logic       scan_done;
  logic       busy;
  logic [2:0] state_dbg;

  logic [PRICE_W-1:0] ram_mem [256];
  logic [ADDR_W-1:0]  exp_q [$];

  int total = 0;
  int bad   = 0;

  pair_scan_controller_if #(.PRICE_W(PRICE_W), .ADDR_W(ADDR_W), .PAIR_W(PAIR_W)) bus ();

  pair_scan_controller #(
    .NUM_PAIRS(NUM_PAIRS), .PRICE_W(PRICE_W), .ADDR_W(ADDR_W),
    .RAM_BASE(0), .THRESHOLD(100), .EXIT_BAND(20)
  ) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .bus(bus),
    .scan_done(scan_done), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_rd_en)
      bus.ram_rd_data <= ram_mem[bus.ram_addr];
  end

  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_order(input string tag, input logic [PAIR_W-1:0] pair,
                             input logic [1:0] pos, input logic [PRICE_W:0] spr);
    check({tag, "_valid"},  32'(bus.order_valid),  32'd1);
    check({tag, "_pair"},   32'(bus.order_pair),   32'(pair));
    check({tag, "_pos"},    32'(bus.order_pos),    32'(pos));
    check({tag, "_spread"}, 32'(bus.order_spread), 32'(spr));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd_en"},  32'(bus.ram_rd_en),    32'd0);
    check({tag, "_addr"},   32'(bus.ram_addr),     32'd0);
    check({tag, "_valid"},  32'(bus.order_valid),  32'd0);
    check({tag, "_pair"},   32'(bus.order_pair),   32'd0);
    check({tag, "_pos"},    32'(bus.order_pos),    32'd0);
    check({tag, "_spread"}, 32'(bus.order_spread), 32'd0);
    check({tag, "_done"},   32'(scan_done),        32'd0);
    check({tag, "_busy"},   32'(busy),             32'd0);
    check({tag, "_state"},  32'(state_dbg),        32'd0);
  endtask

  initial begin
    bus.order_ready = 1'b0;
    bus.ram_rd_data = '0;
    for (int a = 0; a < 256; a++) ram_mem[a] = '0;
    ram_mem[0] = 16'd1200; ram_mem[1] = 16'd1000;  // +200  -> LONG
    ram_mem[2] = 16'd1000; ram_mem[3] = 16'd1300;  // -300  -> SHORT
    ram_mem[4] = 16'd1100; ram_mem[5] = 16'd1000;  // +100  -> no entry
    ram_mem[6] = 16'd500;  ram_mem[7] = 16'd500;   // 0     -> FLAT

    // reset
    step(2);
    check_idle_zero("rst");
    reset = 1'b0;
    step(1);
    check("rst_hold_idle", 32'(state_dbg), 32'd0);

    // T1: entry LONG on pair 0
    scan_en = 1'b1;
    step(1);
    check("t1_rd1_en",   32'(bus.ram_rd_en), 32'd1);
    check("t1_rd1_addr", 32'(bus.ram_addr),  32'd0);
    check("t1_busy",     32'(busy),          32'd1);
    step(1);
    check("t1_rd2_addr", 32'(bus.ram_addr),  32'd1);
    step(1);
    check("t1_cap_rd_en", 32'(bus.ram_rd_en), 32'd0);
    step(1);
    check("t1_eval_valid", 32'(bus.order_valid), 32'd0);
    step(1);
    check_order("t1", 2'd0, 2'b01, 17'd200);
    bus.order_ready = 1'b1;
    step(1);
    bus.order_ready = 1'b0;
    check("t1_next_addr", 32'(bus.ram_addr), 32'd2);
    check("t1_after_valid", 32'(bus.order_valid), 32'd0);

    // T2: SHORT on pair 1 with a 5-cycle ready stall
    step(4);
    check_order("t2", 2'd1, 2'b10, 17'h1_FED4);
    for (int s = 0; s < 5; s++) begin
      step(1);
      check_order("t2_stall", 2'd1, 2'b10, 17'h1_FED4);
      check("t2_stall_rd_en", 32'(bus.ram_rd_en), 32'd0);
    end
    bus.order_ready = 1'b1;
    step(1);
    bus.order_ready = 1'b0;
    check("t2_next_addr", 32'(bus.ram_addr), 32'd4);

    // T3a: spread exactly +THRESHOLD from FLAT gives no order
    step(3);
    check("t3_eval_state", 32'(state_dbg), 32'd4);
    check("t3_eq_thr_valid", 32'(bus.order_valid), 32'd0);
    step(1);
    check("t3_pair3_addr", 32'(bus.ram_addr), 32'd6);
    step(4);
    check("t3_scan_done", 32'(scan_done), 32'd1);
    check("t3_wrap_addr", 32'(bus.ram_addr), 32'd0);

    // T3b/T4: +50 while LONG holds; whole scan without orders
    ram_mem[0] = 16'd1050;
    for (int a = 0; a < 8; a++) exp_q.push_back(ADDR_W'(a));
    for (int k = 0; k < 16; k++) begin
      if ((k % 4) < 2) begin
        check("t4_rd_en", 32'(bus.ram_rd_en), 32'd1);
        if (exp_q.size() > 0)
          check("t4_addr", 32'(bus.ram_addr), 32'(exp_q.pop_front()));
      end else begin
        check("t4_rd_idle", 32'(bus.ram_rd_en), 32'd0);
      end
      check("t4_valid", 32'(bus.order_valid), 32'd0);
      check("t4_done", 32'(scan_done), (k == 0) ? 32'd1 : 32'd0);
      if (k == 4) ram_mem[0] = 16'd1020;
      step(1);
    end
    check("t4_done_period", 32'(scan_done), 32'd1);

    // T3c: +20 while LONG -> exit to FLAT
    step(4);
    check_order("t3_exit", 2'd0, 2'b00, 17'd20);
    bus.order_ready = 1'b1;
    step(1);
    bus.order_ready = 1'b0;
    check("t3_exit_next_addr", 32'(bus.ram_addr), 32'd2);

    // T5: drop scan_en during RD2 of pair 2
    step(4);
    check("t5_pair2_addr", 32'(bus.ram_addr), 32'd4);
    step(1);
    scan_en = 1'b0;
    check("t5_rd2_addr", 32'(bus.ram_addr), 32'd5);
    ram_mem[6] = 16'd2000;
    ram_mem[7] = 16'd1000;
    step(2);
    check("t5_still_busy", 32'(busy), 32'd1);
    step(1);
    check("t5_idle_busy",  32'(busy),          32'd0);
    check("t5_idle_state", 32'(state_dbg),     32'd0);
    check("t5_idle_rd_en", 32'(bus.ram_rd_en), 32'd0);
    step(2);
    check("t5_stay_idle", 32'(busy), 32'd0);
    scan_en = 1'b1;
    step(1);
    check("t5_resume_addr", 32'(bus.ram_addr), 32'd6);

    // T6: reset while an order is pending
    step(4);
    check_order("t6_pre", 2'd3, 2'b01, 17'd1000);
    reset   = 1'b1;
    scan_en = 1'b0;
    step(1);
    check_idle_zero("t6_rst");
    reset   = 1'b0;
    scan_en = 1'b1;
    step(1);
    check("t6_rescan_addr", 32'(bus.ram_addr), 32'd0);
    step(4);
    check("t6_pair1_addr", 32'(bus.ram_addr), 32'd2);
    step(4);
    // pair 1 was SHORT before reset; a fresh SHORT order proves positions cleared
    check_order("t6_reorder", 2'd1, 2'b10, 17'h1_FED4);
    bus.order_ready = 1'b1;
    step(1);
    bus.order_ready = 1'b0;
    check("t6_final_addr", 32'(bus.ram_addr), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
